// File: rtl/clink_pkg.sv
// rtl/clink_pkg.sv - shared defaults and load FSM encoding for the CLINK parameter/data stage
package clink_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int NH_DEFAULT = 5;
    localparam int NW_DEFAULT = NH_DEFAULT + 1;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_FULL = 2'd2
    } ld_state_t;

endpackage

// File: rtl/clink_param_data_ctrl_if.sv
// rtl/clink_param_data_ctrl_if.sv - weight load handshake between host and parameter stage
interface clink_param_data_ctrl_if #(
    parameter int DW = clink_pkg::DW_DEFAULT
);
    logic          param_ld_start;
    logic          param_ld_valid;
    logic [DW-1:0] param_ld_data;
    logic          param_ld_ready;
    logic          param_ld_done;

    modport master (
        output param_ld_start,
        output param_ld_valid,
        output param_ld_data,
        input  param_ld_ready,
        input  param_ld_done
    );

    modport slave (
        input  param_ld_start,
        input  param_ld_valid,
        input  param_ld_data,
        output param_ld_ready,
        output param_ld_done
    );
endinterface

// File: rtl/clink_param_shadow.sv
// rtl/clink_param_shadow.sv - NW-slot shadow weight bank with word counter and frame-done flag
// Word i of a frame lands in slot NW-1-i, so the bias arrives last.
module clink_param_shadow
    import clink_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int NW = NW_DEFAULT
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clear,
    input  logic           wr_en,
    input  logic [DW-1:0]  wr_data,
    output logic [NW*DW-1:0] bank,
    output logic           last,
    output logic           done
);
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    logic [CW-1:0] count;
    logic [CW-1:0] slot;

    assign slot = CW'(NW - 1) - count;
    assign last = (count == CW'(NW - 1));

    // clear restarts the frame but deliberately keeps the old bank contents
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            done  <= 1'b0;
            bank  <= '0;
        end else if (clear) begin
            count <= '0;
            done  <= 1'b0;
        end else if (wr_en) begin
            for (int k = 0; k < NW; k++) begin
                if (slot == CW'(k)) begin
                    bank[k*DW +: DW] <= wr_data;
                end
            end
            count <= last ? '0 : count + 1'b1;
            done  <= last;
        end
    end
endmodule

// File: rtl/clink_param_data_ctrl.sv
// rtl/clink_param_data_ctrl.sv - weight frame load/commit control and per-inference data capture
module clink_param_data_ctrl
    import clink_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int NH = NH_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    clink_param_data_ctrl_if.slave param_ld,
    input  logic                   param_set,
    output logic                   param_set_pend,
    output logic [(NH+1)*DW-1:0]   rec_w,
    input  logic                   clink_start,
    input  logic                   seq_clear,
    input  logic [DW-1:0]          clink_input,
    output logic [DW-1:0]          in_d,
    input  logic [NH*DW-1:0]       h_cur_d,
    output logic [NH*DW-1:0]       h_pre_d,
    output logic                   data_valid
);
    localparam int NW = NH + 1;

    ld_state_t             state;
    ld_state_t             state_nxt;
    logic                  accept;
    logic                  commit;
    logic                  shadow_last;
    logic                  shadow_done;
    logic [NW*DW-1:0]      shadow_bank;

    // a word presented alongside a (re)start is dropped
    assign accept = param_ld.param_ld_valid & param_ld.param_ld_ready & ~param_ld.param_ld_start;
    assign commit = (param_set | param_set_pend) & (state == LD_FULL);

    clink_param_shadow #(
        .DW(DW),
        .NW(NW)
    ) u_shadow (
        .clock  (clock),
        .reset  (reset),
        .clear  (param_ld.param_ld_start),
        .wr_en  (accept),
        .wr_data(param_ld.param_ld_data),
        .bank   (shadow_bank),
        .last   (shadow_last),
        .done   (shadow_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (param_ld.param_ld_start) begin
            state_nxt = LD_LOAD;
        end else if (state == LD_LOAD && accept && shadow_last) begin
            state_nxt = LD_FULL;
        end
    end

    always_comb begin
        param_ld.param_ld_ready = (state == LD_LOAD);
    end

    assign param_ld.param_ld_done = shadow_done;

    // pend is consumed on the first FULL cycle, whatever else happens that cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            param_set_pend <= 1'b0;
            rec_w          <= '0;
        end else begin
            if (state == LD_FULL) begin
                param_set_pend <= 1'b0;
            end else if (param_set) begin
                param_set_pend <= 1'b1;
            end
            if (commit) begin
                rec_w <= shadow_bank;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_d       <= '0;
            h_pre_d    <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= clink_start;
            if (clink_start) begin
                in_d    <= clink_input;
                h_pre_d <= seq_clear ? '0 : h_cur_d;
            end
        end
    end
endmodule

// File: tb/tb_clink_param_data_ctrl.sv
// tb/tb_clink_param_data_ctrl.sv - directed self-checking bench for clink_param_data_ctrl
module tb_clink_param_data_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        param_set;
    logic        param_set_pend;
    logic [95:0] rec_w;
    logic        clink_start;
    logic        seq_clear;
    logic [15:0] clink_input;
    logic [15:0] in_d;
    logic [79:0] h_cur_d;
    logic [79:0] h_pre_d;
    logic        data_valid;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    clink_param_data_ctrl_if #(.DW(16)) bus ();

    clink_param_data_ctrl #(
        .DW(16),
        .NH(5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .param_ld      (bus),
        .param_set     (param_set),
        .param_set_pend(param_set_pend),
        .rec_w         (rec_w),
        .clink_start   (clink_start),
        .seq_clear     (seq_clear),
        .clink_input   (clink_input),
        .in_d          (in_d),
        .h_cur_d       (h_cur_d),
        .h_pre_d       (h_pre_d),
        .data_valid    (data_valid)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.param_ld_start = 1'b0;
        bus.param_ld_valid = 1'b0;
        bus.param_ld_data  = 16'h0000;
        param_set          = 1'b0;
        clink_start        = 1'b0;
        seq_clear          = 1'b0;
        clink_input        = 16'h0000;
        h_cur_d            = '0;
    endtask

    task automatic send_word(input logic [15:0] w);
        bus.param_ld_valid = 1'b1;
        bus.param_ld_data  = w;
        tick();
        bus.param_ld_valid = 1'b0;
    endtask

    task automatic load_start();
        bus.param_ld_start = 1'b1;
        tick();
        bus.param_ld_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [195:0] outs;
        reset = 1'b1;
        bus.param_ld_start = 1'b1;
        bus.param_ld_valid = 1'b1;
        bus.param_ld_data  = 16'hFFFF;
        param_set   = 1'b1;
        clink_start = 1'b1;
        seq_clear   = 1'b0;
        clink_input = 16'hFFFF;
        h_cur_d     = '1;
        tick();
        outs = {rec_w, in_d, h_pre_d, bus.param_ld_ready, bus.param_ld_done, param_set_pend, data_valid};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_cycle: outputs=%h required 0", outs);
        end
        reset = 1'b0;
        idle_inputs();
        tick();
        outs = {rec_w, in_d, h_pre_d, bus.param_ld_ready, bus.param_ld_done, param_set_pend, data_valid};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL after_reset: outputs=%h required 0", outs);
        end
    endtask

    task automatic test_load_gapped();
        logic [15:0] words [6] = '{16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h00B0};
        logic [95:0] exp_w = 96'h0005_0004_0003_0002_0001_00B0;
        load_start();
        checks++;
        if ({bus.param_ld_ready, bus.param_ld_done} !== 2'b10) begin
            errors++;
            $display("FAIL start_ready: ready,done=%b required 10", {bus.param_ld_ready, bus.param_ld_done});
        end
        for (int i = 0; i < 6; i++) begin
            send_word(words[i]);
            checks++;
            if (bus.param_ld_done !== (i == 5)) begin
                errors++;
                $display("FAIL gapped_done_%0d: done=%b required %b", i, bus.param_ld_done, (i == 5));
            end
            tick();
        end
        checks++;
        if (rec_w !== 96'h0) begin
            errors++;
            $display("FAIL precommit_rec_w: rec_w=%h required 0", rec_w);
        end
        param_set = 1'b1;
        tick();
        param_set = 1'b0;
        checks++;
        if (rec_w !== exp_w) begin
            errors++;
            $display("FAIL commit_rec_w: rec_w=%h required %h", rec_w, exp_w);
        end
        checks++;
        if ({bus.param_ld_ready, bus.param_ld_done} !== 2'b01) begin
            errors++;
            $display("FAIL full_flags: ready,done=%b required 01", {bus.param_ld_ready, bus.param_ld_done});
        end
    endtask

    task automatic test_deferred();
        logic [15:0] words [6] = '{16'h0105, 16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h01B0};
        logic [95:0] old_w = 96'h0005_0004_0003_0002_0001_00B0;
        logic [95:0] new_w = 96'h0105_0104_0103_0102_0101_01B0;
        load_start();
        for (int i = 0; i < 3; i++) send_word(words[i]);
        param_set = 1'b1;
        tick();
        param_set = 1'b0;
        checks++;
        if ({param_set_pend, rec_w} !== {1'b1, old_w}) begin
            errors++;
            $display("FAIL defer_pend: pend=%b rec_w=%h required 1 %h", param_set_pend, rec_w, old_w);
        end
        for (int i = 3; i < 6; i++) send_word(words[i]);
        checks++;
        if ({param_set_pend, rec_w} !== {1'b1, old_w}) begin
            errors++;
            $display("FAIL defer_last_word: pend=%b rec_w=%h required 1 %h", param_set_pend, rec_w, old_w);
        end
        tick();
        checks++;
        if ({param_set_pend, rec_w} !== {1'b0, new_w}) begin
            errors++;
            $display("FAIL defer_commit: pend=%b rec_w=%h required 0 %h", param_set_pend, rec_w, new_w);
        end
    endtask

    task automatic test_restart();
        logic [15:0] words [6] = '{16'h0225, 16'h0224, 16'h0223, 16'h0222, 16'h0221, 16'h02C0};
        logic [95:0] exp_w = 96'h0225_0224_0223_0222_0221_02C0;
        load_start();
        send_word(16'h0EEE);
        send_word(16'h0EEF);
        bus.param_ld_start = 1'b1;
        bus.param_ld_valid = 1'b1;
        bus.param_ld_data  = 16'hDEAD;
        tick();
        bus.param_ld_start = 1'b0;
        bus.param_ld_valid = 1'b0;
        checks++;
        if ({bus.param_ld_ready, bus.param_ld_done} !== 2'b10) begin
            errors++;
            $display("FAIL restart_flags: ready,done=%b required 10", {bus.param_ld_ready, bus.param_ld_done});
        end
        for (int i = 0; i < 5; i++) send_word(words[i]);
        checks++;
        if ({bus.param_ld_ready, bus.param_ld_done} !== 2'b10) begin
            errors++;
            $display("FAIL restart_count: ready,done=%b required 10 after 5 words", {bus.param_ld_ready, bus.param_ld_done});
        end
        send_word(words[5]);
        param_set = 1'b1;
        tick();
        param_set = 1'b0;
        checks++;
        if (rec_w !== exp_w) begin
            errors++;
            $display("FAIL restart_rec_w: rec_w=%h required %h", rec_w, exp_w);
        end
    endtask

    task automatic test_set_with_start();
        logic [15:0] words [6] = '{16'h0335, 16'h0334, 16'h0333, 16'h0332, 16'h0331, 16'h03D0};
        logic [95:0] prev_w = 96'h0225_0224_0223_0222_0221_02C0;
        logic [95:0] exp_w  = 96'h0335_0334_0333_0332_0331_03D0;
        load_start();
        for (int i = 0; i < 6; i++) send_word(words[i]);
        checks++;
        if (rec_w !== prev_w) begin
            errors++;
            $display("FAIL full_no_set: rec_w=%h required %h", rec_w, prev_w);
        end
        param_set = 1'b1;
        bus.param_ld_start = 1'b1;
        tick();
        param_set = 1'b0;
        bus.param_ld_start = 1'b0;
        checks++;
        if (rec_w !== exp_w) begin
            errors++;
            $display("FAIL set_start_rec_w: rec_w=%h required %h", rec_w, exp_w);
        end
        checks++;
        if ({bus.param_ld_ready, bus.param_ld_done, param_set_pend} !== 3'b100) begin
            errors++;
            $display("FAIL set_start_flags: ready,done,pend=%b required 100", {bus.param_ld_ready, bus.param_ld_done, param_set_pend});
        end
    endtask

    task automatic test_capture();
        logic [79:0] h = 80'h0055_0044_0033_0022_0011;
        clink_start = 1'b1;
        clink_input = 16'h1234;
        h_cur_d     = h;
        tick();
        clink_start = 1'b0;
        clink_input = 16'hFFFF;
        h_cur_d     = '1;
        checks++;
        if ({in_d, h_pre_d, data_valid} !== {16'h1234, h, 1'b1}) begin
            errors++;
            $display("FAIL capture: in_d=%h h_pre_d=%h dv=%b required 1234 %h 1", in_d, h_pre_d, data_valid, h);
        end
        tick();
        checks++;
        if ({in_d, h_pre_d, data_valid} !== {16'h1234, h, 1'b0}) begin
            errors++;
            $display("FAIL capture_hold: in_d=%h h_pre_d=%h dv=%b required 1234 %h 0", in_d, h_pre_d, data_valid, h);
        end
        clink_start = 1'b1;
        seq_clear   = 1'b1;
        clink_input = 16'h0ABC;
        tick();
        clink_start = 1'b0;
        seq_clear   = 1'b0;
        checks++;
        if ({in_d, h_pre_d, data_valid} !== {16'h0ABC, 80'h0, 1'b1}) begin
            errors++;
            $display("FAIL seq_clear: in_d=%h h_pre_d=%h dv=%b required 0abc 0 1", in_d, h_pre_d, data_valid);
        end
    endtask

    task automatic test_back_to_back();
        clink_start = 1'b1;
        clink_input = 16'h1111;
        h_cur_d     = 80'h0001_0002_0003_0004_0005;
        tick();
        checks++;
        if ({in_d, data_valid} !== {16'h1111, 1'b1}) begin
            errors++;
            $display("FAIL b2b_first: in_d=%h dv=%b required 1111 1", in_d, data_valid);
        end
        clink_input = 16'h2222;
        tick();
        clink_start = 1'b0;
        checks++;
        if ({in_d, h_pre_d, data_valid} !== {16'h2222, 80'h0001_0002_0003_0004_0005, 1'b1}) begin
            errors++;
            $display("FAIL b2b_second: in_d=%h h_pre_d=%h dv=%b required 2222 with dv 1", in_d, h_pre_d, data_valid);
        end
        tick();
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: dv=%b required 0", data_valid);
        end
    endtask

    task automatic test_reset_mid_load();
        load_start();
        send_word(16'h0777);
        send_word(16'h0778);
        param_set = 1'b1;
        tick();
        param_set = 1'b0;
        checks++;
        if (param_set_pend !== 1'b1) begin
            errors++;
            $display("FAIL midload_pend: pend=%b required 1", param_set_pend);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({bus.param_ld_ready, bus.param_ld_done, param_set_pend, rec_w} !== 99'h0) begin
            errors++;
            $display("FAIL midload_reset: ready,done,pend=%b rec_w=%h required 000 0", {bus.param_ld_ready, bus.param_ld_done, param_set_pend}, rec_w);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_load_gapped();
        test_deferred();
        test_restart();
        test_set_with_start();
        test_capture();
        test_back_to_back();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clink_param_data_ctrl.md
# clink_param_data_ctrl

Parametrised successor to the CLINK parameter/data update stage. It sits between the host load port and the recurrent datapath. It accepts a frame of NH+1 weight words over a valid/ready handshake into a shadow bank, and commits that bank to the active weights on request, deferring the commit if the frame is incomplete. Per inference it captures the input sample and the previous hidden states, with an optional sequence-clear that zeroes the recurrent state.

## Interface
Parameters:
- DW, 16, data/weight word width (signed fixed point, passed through untouched)
- NH, 5, hidden node count; weight count NW = NH+1 (bias + one per node)

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- param_ld_start  in  1  start (or restart) a load frame
- param_ld_valid  in  1  param_ld_data valid this cycle
- param_ld_data  in  DW  weight word
- param_ld_ready  out  1  block accepts a word this cycle
- param_ld_done  out  1  shadow bank holds a complete frame
- param_set  in  1  request commit of shadow bank to active weights
- param_set_pend  out  1  commit requested, waiting for frame completion
- rec_w  out  NW*DW  active weights; slice 0 = bias, slice k = w_k
- clink_start  in  1  capture inputs for one inference
- seq_clear  in  1  qualifies clink_start; load zeros into h_pre_d
- clink_input  in  DW  input sample
- in_d  out  DW  captured input sample
- h_cur_d  in  NH*DW  current hidden states, slice k-1 = node k
- h_pre_d  out  NH*DW  captured previous hidden states
- data_valid  out  1  one-cycle pulse after each capture

## Operation
- Load FSM states: IDLE (ready=0, done=0), LOAD (ready=1), FULL (ready=0, done=1).
- param_ld_start in any state: word counter <= 0, state <= LOAD, done <= 0. Shadow contents are not cleared. Any word presented in the same cycle is discarded.
- In LOAD, a word is accepted when valid & ready. Word i of the frame (i = 0..NW-1) is written to shadow slice NW-1-i. Frame order is therefore w_NH … w1, bias last.
- The counter increments per accepted word. Acceptance of word NW-1 transitions the FSM to FULL.
- param_set while in FULL: rec_w <= shadow. The FSM stays in FULL, and repeated sets re-commit the same frame.
- param_set while not in FULL: param_set_pend <= 1, and the committed rec_w is unchanged. Pending commits execute on the first cycle the FSM is in FULL, and pend then clears. Pend survives param_ld_start. A param_set while pend=1 has no additional effect.
- param_set together with param_ld_start while in FULL: the old complete shadow is committed, and the load restarts.
- clink_start: in_d <= clink_input. h_pre_d <= seq_clear ? 0 : h_cur_d. data_valid pulses the next cycle. Without clink_start, all captured data holds.
- Load and data capture are independent and may occur in the same cycle.

## Timing
- Reset (sync, active-high): state IDLE, counter 0. rec_w, shadow, in_d, h_pre_d all 0. ready, done, pend, data_valid all 0.
- ready asserts the cycle after param_ld_start is sampled.
- done asserts the cycle after the final word is accepted.
- rec_w updates at the edge that samples param_set in FULL, giving latency 1.
- A deferred commit lands at the edge ending the first FULL cycle, i.e. 2 cycles after the final word is accepted.
- in_d and h_pre_d update at the edge sampling clink_start. data_valid is high for exactly the following cycle; back-to-back starts give a continuous high.
- Reset mid-load aborts the frame and drops pend.

## Structure
- Shared package clink_pkg: DW, NH defaults, derived NW, and the load FSM state enum.
- One natural sub-module is clink_param_shadow, an NW-slot indexed write bank with a counter and done flag. The top level holds the FSM-to-commit logic and the data capture registers.

## Test plan
- Reset with all inputs toggling → every output 0 for the reset cycle and the one after.
- Start, then 6 words 0x0005,0x0004,0x0003,0x0002,0x0001,0x00B0 with valid gapped every other cycle, then param_set → rec_w = {w5=5,w4=4,w3=3,w2=2,w1=1,bias=0xB0}, done=1, rec_w 1 cycle after set.
- param_set after 3 of 6 words → pend=1, rec_w unchanged; finish the frame → rec_w updates 2 cycles after the last word, pend drops.
- param_ld_start asserted with a valid word mid-frame → word discarded, counter 0, done=0; full reload gives the new frame only.
- clink_start with clink_input=0x1234, h_cur_d node1..5 = 0x0011..0x0055 → in_d=0x1234, h_pre_d matches, data_valid 1 cycle. Repeat with seq_clear=1 → h_pre_d=0, in_d updates.
- param_set together with param_ld_start while in FULL → old frame committed, ready=1 next cycle, done=0.
